mmio_bridge: RTL and testbench

- Sits directly downstream of the single-cycle core's data port (DataAddr / write_data / write_ena / read_data).
- Decodes each access to either the data RAM (pass-through) or a small MMIO register block.
- The MMIO block contains a byte TX FIFO with a valid/ready sink handshake, and a free-running 32-bit timer with compare and interrupt.
- All reads are combinational, so the single-cycle core completes loads in the same cycle. All writes take effect on the rising clock edge.

---
 rtl/mmio_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/mmio_bridge.sv | 164 ++++++++++++++++
 tb/tb_mmio_bridge.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the MMIO bridge.
//   - Register byte offsets inside the 256-byte MMIO window.
//   - STATUS / CTRL bit positions.
//   - sat_nibble(): clamps a count to the 4-bit STATUS count field.
package mmio_pkg;

    localparam logic [7:0] OFF_TX_DATA   = 8'h00;
    localparam logic [7:0] OFF_STATUS    = 8'h04;
    localparam logic [7:0] OFF_TIMER     = 8'h08;
    localparam logic [7:0] OFF_TIMER_CMP = 8'h0C;
    localparam logic [7:0] OFF_CTRL      = 8'h10;
    localparam logic [7:0] OFF_TXCNT     = 8'h14;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_MATCH   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    localparam int CTRL_TIMER_EN = 0;
    localparam int CTRL_IRQ_EN   = 1;

    // STATUS only has four bits for the FIFO count; deeper FIFOs show 15.
    function automatic logic [3:0] sat_nibble(input logic [31:0] v);
        return (v > 32'd15) ? 4'hF : v[3:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, no bypass (data written this cycle is
// visible at the head from the next cycle).
// Ports:
//   clk, reset (async, active-low)
//   push/wdata : write request; accepted when not full or when popping
//   pop        : remove head; ignored while empty
//   rdata      : head entry (storage reset to 0, so reads 0 after reset)
//   full, empty, count (log2(DEPTH)+1 bits)
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_do_pop;
    logic w_do_push;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];

    assign w_do_pop  = pop & ~empty;
    // A pop frees the slot in the same edge, so a push into a full FIFO
    // is fine when it coincides with a pop.
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_bridge.sv
// mmio_bridge: decodes the single-cycle core's data port into RAM
// pass-through or a small MMIO block (TX byte FIFO + 32-bit timer).
// Reads are combinational; writes commit on the rising edge.
// Ports:
//   clk, reset (async, active-low)
//   DataAddr, write_data, write_ena, read_data : core data port
//   ram_a, ram_wd, ram_we, ram_rd              : data RAM port
//   tx_data, tx_valid, tx_ready                : byte sink handshake
//   irq                                        : timer interrupt (level)
// Build option: MMIO_TX_COUNT_EN adds read-only TXCNT (popped-byte count)
// at offset 0x14; otherwise that offset is unmapped.
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter logic [31:0] MMIO_BASE  = 32'h8000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] DataAddr,
    input  logic [31:0] write_data,
    input  logic        write_ena,
    output logic [31:0] read_data,
    output logic [31:0] ram_a,
    output logic [31:0] ram_wd,
    output logic        ram_we,
    input  logic [31:0] ram_rd,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          w_is_mmio;
    logic [5:0]    w_off;
    logic          w_wr;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [3:0]    w_cnt_disp;
    logic          w_match_set;
    logic [31:0]   w_status;
    logic          w_unused_addr;

    logic [31:0]   r_timer;
    logic [31:0]   r_cmp;
    logic          r_timer_en;
    logic          r_irq_en;
    logic          r_match;
    logic          r_ovf;
`ifdef MMIO_TX_COUNT_EN
    logic [31:0]   r_txcnt;
`endif

    // Register decode ignores the byte lane bits.
    assign w_is_mmio     = (DataAddr[31:8] == MMIO_BASE[31:8]);
    assign w_off         = DataAddr[7:2];
    assign w_unused_addr = ^DataAddr[1:0];
    assign w_wr          = write_ena & w_is_mmio;

    assign ram_a  = DataAddr;
    assign ram_wd = write_data;
    assign ram_we = write_ena & ~w_is_mmio;

    assign w_push   = w_wr & (w_off == OFF_TX_DATA[7:2]);
    assign w_pop    = ~w_empty & tx_ready;
    assign tx_valid = ~w_empty;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (write_data[7:0]),
        .rdata (tx_data),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign w_cnt_disp  = sat_nibble(32'(w_count));
    assign w_match_set = r_timer_en & (r_timer == r_cmp);
    assign irq         = r_match & r_irq_en;

    always_comb begin
        w_status                          = '0;
        w_status[ST_FULL]                 = w_full;
        w_status[ST_EMPTY]                = w_empty;
        w_status[ST_MATCH]                = r_match;
        w_status[ST_OVF]                  = r_ovf;
        w_status[ST_CNT_LSB+3:ST_CNT_LSB] = w_cnt_disp;
    end

    always_comb begin
        read_data = '0;
        if (!w_is_mmio) begin
            read_data = ram_rd;
        end else begin
            case (w_off)
                OFF_STATUS[7:2]:    read_data = w_status;
                OFF_TIMER[7:2]:     read_data = r_timer;
                OFF_TIMER_CMP[7:2]: read_data = r_cmp;
                OFF_CTRL[7:2]: begin
                    read_data[CTRL_TIMER_EN] = r_timer_en;
                    read_data[CTRL_IRQ_EN]   = r_irq_en;
                end
`ifdef MMIO_TX_COUNT_EN
                OFF_TXCNT[7:2]:     read_data = r_txcnt;
`endif
                default:            read_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer    <= '0;
            r_cmp      <= '0;
            r_timer_en <= 1'b0;
            r_irq_en   <= 1'b0;
            r_match    <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_wr && w_off == OFF_TIMER[7:2])
                r_timer <= write_data;
            else if (r_timer_en)
                r_timer <= r_timer + 32'd1;

            if (w_wr && w_off == OFF_TIMER_CMP[7:2])
                r_cmp <= write_data;

            if (w_wr && w_off == OFF_CTRL[7:2]) begin
                r_timer_en <= write_data[CTRL_TIMER_EN];
                r_irq_en   <= write_data[CTRL_IRQ_EN];
            end

            // Sticky flags: a new set event wins over a same-cycle clear.
            if (w_match_set)
                r_match <= 1'b1;
            else if (w_wr && w_off == OFF_STATUS[7:2] && write_data[ST_MATCH])
                r_match <= 1'b0;

            if (w_push && w_full && !w_pop)
                r_ovf <= 1'b1;
            else if (w_wr && w_off == OFF_STATUS[7:2] && write_data[ST_OVF])
                r_ovf <= 1'b0;
        end
    end

`ifdef MMIO_TX_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     r_txcnt <= '0;
        else if (w_pop) r_txcnt <= r_txcnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mmio_bridge.sv
module tb_mmio_bridge;

    logic        clk;
    logic        reset;
    logic [31:0] DataAddr;
    logic [31:0] write_data;
    logic        write_ena;
    logic [31:0] read_data;
    logic [31:0] ram_a;
    logic [31:0] ram_wd;
    logic        ram_we;
    logic [31:0] ram_rd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq;

    int vectors;
    int miscompares;
    logic [7:0] sb[$];

    localparam logic [31:0] A_TX    = 32'h8000_0000;
    localparam logic [31:0] A_ST    = 32'h8000_0004;
    localparam logic [31:0] A_TIM   = 32'h8000_0008;
    localparam logic [31:0] A_CMP   = 32'h8000_000C;
    localparam logic [31:0] A_CTRL  = 32'h8000_0010;
    localparam logic [31:0] A_TXCNT = 32'h8000_0014;

    mmio_bridge dut (
        .clk        (clk),
        .reset      (reset),
        .DataAddr   (DataAddr),
        .write_data (write_data),
        .write_ena  (write_ena),
        .read_data  (read_data),
        .ram_a      (ram_a),
        .ram_wd     (ram_wd),
        .ram_we     (ram_we),
        .ram_rd     (ram_rd),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sink side of the scoreboard: a byte is consumed whenever valid and
    // ready are both high just before the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (reset && tx_valid && tx_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL tx_pop_unexpected: got %02h, required no byte", tx_data);
                end else begin
                    logic [7:0] exp_b;
                    exp_b = sb.pop_front();
                    if (tx_data !== exp_b) begin
                        miscompares++;
                        $display("FAIL tx_pop: got %02h, required %02h", tx_data, exp_b);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one store for one cycle; called at a negedge, returns at the next.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        DataAddr   = a;
        write_data = d;
        write_ena  = 1'b1;
        @(negedge clk);
        write_ena  = 1'b0;
    endtask

    // Combinational load; no clock edge consumed.
    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        DataAddr  = a;
        write_ena = 1'b0;
        #1;
        d = read_data;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        rd(A_ST, d);
        vectors++;
        if (d !== 32'h02) begin miscompares++; $display("FAIL reset_status: got %08h, required 00000002", d); end
        rd(A_TIM, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL reset_timer: got %08h, required 0", d); end
        vectors++;
        if ({tx_valid, irq, tx_data} !== 10'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%0b irq=%0b data=%02h, required 0/0/00", tx_valid, irq, tx_data);
        end
    endtask

    task automatic test_ram_passthrough;
        logic [31:0] d;
        @(negedge clk);
        ram_rd     = 32'h1234_5678;
        DataAddr   = 32'h0000_0040;
        write_data = 32'hDEAD_BEEF;
        write_ena  = 1'b1;
        #1;
        vectors++;
        if ({ram_we, ram_a, ram_wd} !== {1'b1, 32'h40, 32'hDEAD_BEEF}) begin
            miscompares++;
            $display("FAIL ram_store: got we=%0b a=%08h wd=%08h, required 1/00000040/deadbeef", ram_we, ram_a, ram_wd);
        end
        @(negedge clk);
        write_ena = 1'b0;
        #1;
        vectors++;
        if (ram_we !== 1'b0) begin miscompares++; $display("FAIL ram_we_pulse: got %0b, required 0", ram_we); end
        rd(32'h0000_0040, d);
        vectors++;
        if (d !== 32'h1234_5678) begin miscompares++; $display("FAIL ram_load: got %08h, required 12345678", d); end
        // RAM stores whose low address bits alias MMIO offsets.
        wr(32'h0000_0000, 32'h77);
        wr(32'h0000_0008, 32'h55);
        rd(A_ST, d);
        vectors++;
        if (d !== 32'h02) begin miscompares++; $display("FAIL ram_no_mmio_status: got %08h, required 00000002", d); end
        rd(A_TIM, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL ram_no_mmio_timer: got %08h, required 0", d); end
        // MMIO store must not reach RAM; unmapped offset reads 0.
        DataAddr = 32'h8000_0020; write_data = 32'hFFFF_FFFF; write_ena = 1'b1;
        #1;
        vectors++;
        if (ram_we !== 1'b0) begin miscompares++; $display("FAIL mmio_no_ram_we: got %0b, required 0", ram_we); end
        @(negedge clk);
        write_ena = 1'b0;
        rd(32'h8000_0020, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL unmapped_read: got %08h, required 0", d); end
    endtask

    task automatic test_fifo_fill_drain;
        logic [31:0] d;
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr(A_TX, 32'h41 + i);
            if (i < 8) sb.push_back(8'(8'h41 + i));
        end
        rd(A_ST, d);
        // count 8, full, overflow; empty clear.
        vectors++;
        if (d !== 32'h89) begin miscompares++; $display("FAIL fill_status: got %08h, required 00000089", d); end
        vectors++;
        if ({tx_valid, tx_data} !== {1'b1, 8'h41}) begin
            miscompares++;
            $display("FAIL fill_head: got valid=%0b data=%02h, required 1/41", tx_valid, tx_data);
        end
        tx_ready = 1'b1;
        repeat (8) @(negedge clk);
        tx_ready = 1'b0;
        rd(A_ST, d);
        vectors++;
        if (d !== 32'h0A) begin miscompares++; $display("FAIL drain_status: got %08h, required 0000000a", d); end
        vectors++;
        if (tx_valid !== 1'b0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain_done: got valid=%0b left=%0d, required 0/0", tx_valid, sb.size());
        end
        wr(A_ST, 32'h8);
        rd(A_ST, d);
        vectors++;
        if (d !== 32'h02) begin miscompares++; $display("FAIL ovf_w1c: got %08h, required 00000002", d); end
    endtask

    task automatic test_full_push_pop;
        logic [31:0] d;
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr(A_TX, 32'h50 + i);
            sb.push_back(8'(8'h50 + i));
        end
        tx_ready = 1'b1;
        sb.push_back(8'h5A);
        wr(A_TX, 32'h5A);
        tx_ready = 1'b0;
        rd(A_ST, d);
        vectors++;
        if (d !== 32'h81) begin miscompares++; $display("FAIL full_push_pop_status: got %08h, required 00000081", d); end
        tx_ready = 1'b1;
        repeat (8) @(negedge clk);
        tx_ready = 1'b0;
        #1;
        vectors++;
        if (tx_valid !== 1'b0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL full_push_pop_drain: got valid=%0b left=%0d, required 0/0", tx_valid, sb.size());
        end
    endtask

    task automatic test_timer_irq;
        logic [31:0] d;
        logic [31:0] exp_t [3];
        exp_t[0] = 32'hFFFF_FFFF; exp_t[1] = 32'h0; exp_t[2] = 32'h1;
        wr(A_TIM, 32'hFFFF_FFFE);
        wr(A_CMP, 32'h1);
        wr(A_CTRL, 32'h3);
        rd(A_TIM, d);
        vectors++;
        if (d !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL timer_load: got %08h, required fffffffe", d); end
        rd(A_CTRL, d);
        vectors++;
        if (d !== 32'h3) begin miscompares++; $display("FAIL ctrl_read: got %08h, required 00000003", d); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rd(A_TIM, d);
            vectors++;
            if (d !== exp_t[i]) begin miscompares++; $display("FAIL timer_count%0d: got %08h, required %08h", i, d, exp_t[i]); end
        end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_early: got %0b, required 0", irq); end
        @(negedge clk);
        rd(A_ST, d);
        vectors++;
        if (d !== 32'h06 || irq !== 1'b1) begin
            miscompares++;
            $display("FAIL match_irq: got status=%08h irq=%0b, required 00000006/1", d, irq);
        end
        wr(A_ST, 32'h4);
        rd(A_ST, d);
        vectors++;
        if (d !== 32'h02 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_clear: got status=%08h irq=%0b, required 00000002/0", d, irq);
        end
        wr(A_CTRL, 32'hFFFF_FFFC);
        rd(A_CTRL, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL ctrl_upper_bits: got %08h, required 0", d); end
    endtask

    task automatic test_async_reset;
        logic [31:0] d;
        wr(A_CTRL, 32'h1);
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr(A_TX, 32'h70 + i);
            sb.push_back(8'(8'h70 + i));
        end
        tx_ready = 1'b1;
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        vectors++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h0) begin
            miscompares++;
            $display("FAIL async_reset_valid: got valid=%0b data=%02h, required 0/00", tx_valid, tx_data);
        end
        tx_ready = 1'b0;
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        rd(A_ST, d);
        vectors++;
        if (d !== 32'h02) begin miscompares++; $display("FAIL post_reset_status: got %08h, required 00000002", d); end
        rd(A_TIM, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL post_reset_timer: got %08h, required 0", d); end
    endtask

    task automatic test_txcnt;
        logic [31:0] d;
        logic [31:0] exp_c;
`ifdef MMIO_TX_COUNT_EN
        exp_c = 32'd5;
`else
        exp_c = 32'd0;
`endif
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr(A_TX, 32'h61 + i);
            sb.push_back(8'(8'h61 + i));
        end
        tx_ready = 1'b1;
        repeat (5) @(negedge clk);
        tx_ready = 1'b0;
        rd(A_TXCNT, d);
        vectors++;
        if (d !== exp_c) begin miscompares++; $display("FAIL txcnt: got %08h, required %08h", d, exp_c); end
        wr(A_TXCNT, 32'd99);
        rd(A_TXCNT, d);
        vectors++;
        if (d !== exp_c) begin miscompares++; $display("FAIL txcnt_ro: got %08h, required %08h", d, exp_c); end
        vectors++;
        if (sb.size() != 0) begin miscompares++; $display("FAIL txcnt_drain: got %0d left, required 0", sb.size()); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        DataAddr    = '0;
        write_data  = '0;
        write_ena   = 1'b0;
        ram_rd      = '0;
        tx_ready    = 1'b0;
        #1;
        test_reset();
        test_ram_passthrough();
        test_fifo_fill_drain();
        test_full_push_pop();
        test_timer_irq();
        test_async_reset();
        test_txcnt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
